// File: rtl/ram32x4_seq_ctrl.sv
// Built-in fill/check sequencer for a 32x4 single-port RAM: writes a seeded
// pattern, reads it back through a latency-matched compare pipeline, and reports errors.
module ram32x4_seq_ctrl #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [3:0]        seed,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              done,
    output logic              err_flag,
    output logic [5:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [2:0] {IDLE, FILL, CHECK, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] seed_q;
    logic [1:0]        drain_cnt;

    logic              issue_valid;
    logic [DATA_W-1:0] issue_exp;
    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] cmp_exp;
    logic              mismatch;

    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                  input logic [ADDR_W-1:0] a);
        return s + a[DATA_W-1:0];
    endfunction

    assign issue_valid = (state == CHECK);
    assign issue_exp   = pattern(seed_q, ram_address);

    // Address and expected value are delayed to line up with ram_q arriving RD_LAT cycles later.
    if (RD_LAT == 0) begin : g_direct
        assign cmp_valid = issue_valid;
        assign cmp_addr  = ram_address;
        assign cmp_exp   = issue_exp;
    end else begin : g_pipe
        logic [RD_LAT-1:0] v_pipe;
        logic [ADDR_W-1:0] a_pipe [RD_LAT];
        logic [DATA_W-1:0] e_pipe [RD_LAT];

        always_ff @(posedge clk) begin
            if (!resetn) begin
                v_pipe <= '0;
            end else begin
                v_pipe[0] <= issue_valid;
                for (int i = 1; i < RD_LAT; i++) begin
                    v_pipe[i] <= v_pipe[i-1];
                end
            end
            a_pipe[0] <= ram_address;
            e_pipe[0] <= issue_exp;
            for (int i = 1; i < RD_LAT; i++) begin
                a_pipe[i] <= a_pipe[i-1];
                e_pipe[i] <= e_pipe[i-1];
            end
        end

        assign cmp_valid = v_pipe[RD_LAT-1];
        assign cmp_addr  = a_pipe[RD_LAT-1];
        assign cmp_exp   = e_pipe[RD_LAT-1];
    end

    assign mismatch = cmp_valid && (ram_q != cmp_exp);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            mode_q         <= '0;
            seed_q         <= '0;
            drain_cnt      <= '0;
            ram_address    <= '0;
            ram_data       <= '0;
            ram_wren       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_flag       <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            done <= 1'b0;

            // Entering CHECK below overrides this; the pipeline is always empty at that edge.
            if (mismatch) begin
                err_count <= err_count + 6'd1;
                err_flag  <= 1'b1;
                if (err_count == '0) begin
                    first_err_addr <= cmp_addr;
                end
            end

            case (state)
                IDLE: begin
                    ram_address <= '0;
                    ram_data    <= '0;
                    ram_wren    <= 1'b0;
                    busy        <= 1'b0;
                    if (start) begin
                        mode_q <= mode;
                        seed_q <= seed;
                        case (mode)
                            2'd0, 2'd2: begin
                                state    <= FILL;
                                ram_wren <= 1'b1;
                                ram_data <= pattern(seed, '0);
                                busy     <= 1'b1;
                            end
                            2'd1: begin
                                state          <= CHECK;
                                busy           <= 1'b1;
                                err_count      <= '0;
                                err_flag       <= 1'b0;
                                first_err_addr <= '0;
                            end
                            default: begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end

                FILL: begin
                    if (ram_address == LAST_ADDR) begin
                        ram_address <= '0;
                        ram_data    <= '0;
                        ram_wren    <= 1'b0;
                        if (mode_q == 2'd2) begin
                            state          <= CHECK;
                            err_count      <= '0;
                            err_flag       <= 1'b0;
                            first_err_addr <= '0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        ram_address <= ram_address + 1'b1;
                        ram_data    <= pattern(seed_q, ram_address + 1'b1);
                    end
                end

                CHECK: begin
                    if (ram_address == LAST_ADDR) begin
                        ram_address <= '0;
                        if (RD_LAT == 0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end else begin
                        ram_address <= ram_address + 1'b1;
                    end
                end

                DRAIN: begin
                    if (drain_cnt == 2'(RD_LAT - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram32x4_seq_ctrl.sv
// Bench for ram32x4_seq_ctrl: three instances (RD_LAT 1, 0, 3) share one command
// stream, each with its own RAM model; results are compared to a word-level reference.
module tb_ram32x4_seq_ctrl;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] mode;
    logic [3:0] seed;

    logic [4:0] ram_address    [NI];
    logic [3:0] ram_data       [NI];
    logic       ram_wren       [NI];
    logic [3:0] ram_q          [NI];
    logic       busy           [NI];
    logic       done           [NI];
    logic       err_flag       [NI];
    logic [5:0] err_count      [NI];
    logic [4:0] first_err_addr [NI];

    ram32x4_seq_ctrl #(.RD_LAT(1)) u_dut_lat1 (
        .clk(clk), .resetn(resetn), .start(start), .mode(mode), .seed(seed),
        .ram_address(ram_address[0]), .ram_data(ram_data[0]), .ram_wren(ram_wren[0]),
        .ram_q(ram_q[0]), .busy(busy[0]), .done(done[0]), .err_flag(err_flag[0]),
        .err_count(err_count[0]), .first_err_addr(first_err_addr[0])
    );

    ram32x4_seq_ctrl #(.RD_LAT(0)) u_dut_lat0 (
        .clk(clk), .resetn(resetn), .start(start), .mode(mode), .seed(seed),
        .ram_address(ram_address[1]), .ram_data(ram_data[1]), .ram_wren(ram_wren[1]),
        .ram_q(ram_q[1]), .busy(busy[1]), .done(done[1]), .err_flag(err_flag[1]),
        .err_count(err_count[1]), .first_err_addr(first_err_addr[1])
    );

    ram32x4_seq_ctrl #(.RD_LAT(3)) u_dut_lat3 (
        .clk(clk), .resetn(resetn), .start(start), .mode(mode), .seed(seed),
        .ram_address(ram_address[2]), .ram_data(ram_data[2]), .ram_wren(ram_wren[2]),
        .ram_q(ram_q[2]), .busy(busy[2]), .done(done[2]), .err_flag(err_flag[2]),
        .err_count(err_count[2]), .first_err_addr(first_err_addr[2])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models; stuck[] forces bit0 high on read at the marked addresses.
    logic [3:0] mem [NI][32];
    logic       stuck [32];
    logic [3:0] rd_lat1;
    logic [3:0] rd_lat3 [3];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (ram_wren[i]) mem[i][ram_address[i]] <= ram_data[i];
        end
        rd_lat1    <= mem[0][ram_address[0]] | {3'b000, stuck[ram_address[0]]};
        rd_lat3[0] <= mem[2][ram_address[2]] | {3'b000, stuck[ram_address[2]]};
        rd_lat3[1] <= rd_lat3[0];
        rd_lat3[2] <= rd_lat3[1];
    end

    always_comb begin
        ram_q[0] = rd_lat1;
        ram_q[1] = mem[1][ram_address[1]] | {3'b000, stuck[ram_address[1]]};
        ram_q[2] = rd_lat3[2];
    end

    int checks   = 0;
    int failures = 0;

    int ref_mem [32];
    int exp_cnt   = 0;
    int exp_first = 0;

    int         done_cyc    [NI];
    int         done_pulses [NI];
    int         wcnt;
    int         fill_bad;
    logic [3:0] data13;
    logic       busy_first;
    logic       busy_end;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int exp_done(input int m, input int lat);
        if (m == 0) return 33;
        if (m == 1) return 33 + lat;
        if (m == 2) return 65 + lat;
        return 1;
    endfunction

    task automatic model_apply(input int m, input int s);
        if (m == 0 || m == 2) begin
            for (int a = 0; a < 32; a++) ref_mem[a] = (s + a) % 16;
        end
        if (m == 1 || m == 2) begin
            exp_cnt   = 0;
            exp_first = 0;
            for (int a = 0; a < 32; a++) begin
                if ((ref_mem[a] | int'(stuck[a])) != (s + a) % 16) begin
                    if (exp_cnt == 0) exp_first = a;
                    exp_cnt++;
                end
            end
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        start  = 1'b0;
        mode   = 2'd0;
        seed   = 4'd0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        exp_cnt   = 0;
        exp_first = 0;
    endtask

    // Issues one command, then observes a fixed 72-cycle window; with noise, start
    // toggles while busy and is held high through instance 0's DONE cycle.
    task automatic run_cmd(input int m, input int s, input bit noise);
        for (int i = 0; i < NI; i++) begin
            done_cyc[i]    = -1;
            done_pulses[i] = 0;
        end
        wcnt     = 0;
        fill_bad = 0;
        data13   = 4'hF;
        @(posedge clk);
        #1 start = 1'b1;
        mode  = 2'(m);
        seed  = 4'(s);
        @(posedge clk);
        #1;
        for (int k = 0; k < 72; k++) begin
            for (int i = 0; i < NI; i++) begin
                if (done[i]) begin
                    done_pulses[i]++;
                    if (done_cyc[i] < 0) done_cyc[i] = k + 1;
                end
            end
            if (ram_wren[0]) begin
                if (ram_address[0] !== 5'(wcnt) || ram_data[0] !== 4'((s + wcnt) % 16)) fill_bad++;
                if (ram_address[0] == 5'd13) data13 = ram_data[0];
                wcnt++;
            end
            if (k == 0)  busy_first = busy[0];
            if (k == 71) busy_end   = busy[0];
            if (noise && k < 59)      start = 1'($urandom_range(0, 1));
            else if (noise && k < 66) start = 1'b1;
            else                      start = 1'b0;
            mode = 2'($urandom_range(0, 3));
            seed = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        model_apply(m, s);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({ram_address[i], ram_data[i], ram_wren[i], busy[i], done[i], err_flag[i],
                 err_count[i], first_err_addr[i]} !== 24'h0) begin
                failures++;
                $display("[TB] FAIL reset_outputs inst%0d: got %h want 0", i,
                         {ram_address[i], ram_data[i], ram_wren[i], busy[i], done[i],
                          err_flag[i], err_count[i], first_err_addr[i]});
            end
        end
    endtask

    task automatic test_fill();
        do_reset();
        run_cmd(0, 3, 1'b0);
        checks++;
        if (wcnt !== 32) begin
            failures++;
            $display("[TB] FAIL fill_wren_cycles: got %0d want 32", wcnt);
        end
        checks++;
        if (fill_bad !== 0) begin
            failures++;
            $display("[TB] FAIL fill_addr_data: got %0d bad cycles want 0", fill_bad);
        end
        checks++;
        if (data13 !== 4'h0) begin
            failures++;
            $display("[TB] FAIL fill_data_addr13: got %h want 0", data13);
        end
        checks++;
        if (busy_first !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fill_busy_n1: got %b want 1", busy_first);
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (done_cyc[i] !== 33 || done_pulses[i] !== 1) begin
                failures++;
                $display("[TB] FAIL fill_done inst%0d: got cycle %0d pulses %0d want 33/1",
                         i, done_cyc[i], done_pulses[i]);
            end
            checks++;
            if ({err_flag[i], err_count[i], first_err_addr[i]} !== 12'h0) begin
                failures++;
                $display("[TB] FAIL fill_err_outputs inst%0d: got %b/%0d/%0d want 0/0/0",
                         i, err_flag[i], err_count[i], first_err_addr[i]);
            end
        end
    endtask

    task automatic test_fill_check(input int s, input string tag);
        run_cmd(2, s, 1'b0);
        checks++;
        if (wcnt !== 32) begin
            failures++;
            $display("[TB] FAIL %s_wren_cycles: got %0d want 32", tag, wcnt);
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (done_cyc[i] !== exp_done(2, lat_of(i)) || done_pulses[i] !== 1) begin
                failures++;
                $display("[TB] FAIL %s_done inst%0d: got cycle %0d pulses %0d want %0d/1",
                         tag, i, done_cyc[i], done_pulses[i], exp_done(2, lat_of(i)));
            end
            checks++;
            if ({err_flag[i], err_count[i], first_err_addr[i]} !==
                {exp_cnt != 0, 6'(exp_cnt), 5'(exp_first)}) begin
                failures++;
                $display("[TB] FAIL %s_errors inst%0d: got %b/%0d/%0d want %b/%0d/%0d", tag, i,
                         err_flag[i], err_count[i], first_err_addr[i],
                         exp_cnt != 0, exp_cnt, exp_first);
            end
        end
    endtask

    task automatic test_all_mismatch();
        run_cmd(0, 5, 1'b0);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({err_flag[i], err_count[i], first_err_addr[i]} !==
                {exp_cnt != 0, 6'(exp_cnt), 5'(exp_first)}) begin
                failures++;
                $display("[TB] FAIL fill_keeps_errors inst%0d: got %b/%0d/%0d want %b/%0d/%0d", i,
                         err_flag[i], err_count[i], first_err_addr[i],
                         exp_cnt != 0, exp_cnt, exp_first);
            end
        end
        run_cmd(1, 6, 1'b0);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (done_cyc[i] !== exp_done(1, lat_of(i)) || done_pulses[i] !== 1) begin
                failures++;
                $display("[TB] FAIL check_done inst%0d: got cycle %0d pulses %0d want %0d/1",
                         i, done_cyc[i], done_pulses[i], exp_done(1, lat_of(i)));
            end
            checks++;
            if ({err_flag[i], err_count[i], first_err_addr[i]} !== {1'b1, 6'd32, 5'd0}) begin
                failures++;
                $display("[TB] FAIL all_mismatch inst%0d: got %b/%0d/%0d want 1/32/0", i,
                         err_flag[i], err_count[i], first_err_addr[i]);
            end
        end
    endtask

    task automatic test_mode3();
        run_cmd(3, 9, 1'b0);
        checks++;
        if (wcnt !== 0) begin
            failures++;
            $display("[TB] FAIL mode3_no_writes: got %0d want 0", wcnt);
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (done_cyc[i] !== 1 || done_pulses[i] !== 1) begin
                failures++;
                $display("[TB] FAIL mode3_done inst%0d: got cycle %0d pulses %0d want 1/1",
                         i, done_cyc[i], done_pulses[i]);
            end
            checks++;
            if ({err_flag[i], err_count[i], first_err_addr[i]} !==
                {exp_cnt != 0, 6'(exp_cnt), 5'(exp_first)}) begin
                failures++;
                $display("[TB] FAIL mode3_errors inst%0d: got %b/%0d/%0d want %b/%0d/%0d", i,
                         err_flag[i], err_count[i], first_err_addr[i],
                         exp_cnt != 0, exp_cnt, exp_first);
            end
        end
    endtask

    task automatic test_abort();
        bit found = 1'b0;
        int stray = 0;
        do_reset();
        @(posedge clk);
        #1 start = 1'b1;
        mode  = 2'd0;
        seed  = 4'h2;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (ram_wren[0] && ram_address[0] == 5'd10) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL abort_reach_addr10: got not reached want reached");
        end
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        exp_cnt   = 0;
        exp_first = 0;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({ram_wren[i], busy[i], done[i], ram_address[i]} !== 8'h0) begin
                failures++;
                $display("[TB] FAIL abort_state inst%0d: wren %b busy %b done %b addr %0d want all 0",
                         i, ram_wren[i], busy[i], done[i], ram_address[i]);
            end
        end
        repeat (40) begin
            for (int i = 0; i < NI; i++) begin
                if (done[i] || ram_wren[i] || busy[i]) stray++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("[TB] FAIL abort_no_activity: got %0d active samples want 0", stray);
        end
        run_cmd(0, 7, 1'b0);
        checks++;
        if (wcnt !== 32 || fill_bad !== 0) begin
            failures++;
            $display("[TB] FAIL abort_restart_fill: got %0d writes %0d bad want 32/0", wcnt, fill_bad);
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (done_cyc[i] !== 33 || done_pulses[i] !== 1) begin
                failures++;
                $display("[TB] FAIL abort_restart_done inst%0d: got cycle %0d pulses %0d want 33/1",
                         i, done_cyc[i], done_pulses[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int fs = $urandom_range(0, 15);
            int cs = $urandom_range(0, 15);
            int m;
            for (int a = 0; a < 32; a++) stuck[a] = ($urandom_range(0, 7) == 0);
            if (it % 2 == 0) begin
                m = 2;
                run_cmd(2, fs, 1'b0);
            end else begin
                m = 1;
                run_cmd(0, fs, 1'b0);
                run_cmd(1, cs, 1'b0);
            end
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (done_cyc[i] !== exp_done(m, lat_of(i)) ||
                    {err_flag[i], err_count[i], first_err_addr[i]} !==
                    {exp_cnt != 0, 6'(exp_cnt), 5'(exp_first)}) begin
                    failures++;
                    $display("[TB] FAIL random%0d inst%0d: got done %0d err %b/%0d/%0d want %0d %b/%0d/%0d",
                             it, i, done_cyc[i], err_flag[i], err_count[i], first_err_addr[i],
                             exp_done(m, lat_of(i)), exp_cnt != 0, exp_cnt, exp_first);
                end
            end
        end
        for (int a = 0; a < 32; a++) stuck[a] = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_cmd(2, 6, 1'b1);
        checks++;
        if (done_pulses[0] !== 1 || done_cyc[0] !== 66) begin
            failures++;
            $display("[TB] FAIL b2b_done: got cycle %0d pulses %0d want 66/1", done_cyc[0], done_pulses[0]);
        end
        checks++;
        if (busy_end !== 1'b0 || wcnt !== 32) begin
            failures++;
            $display("[TB] FAIL b2b_no_restart: got busy %b writes %0d want 0/32", busy_end, wcnt);
        end
        checks++;
        if ({err_flag[0], err_count[0], first_err_addr[0]} !== {exp_cnt != 0, 6'(exp_cnt), 5'(exp_first)}) begin
            failures++;
            $display("[TB] FAIL b2b_errors: got %b/%0d/%0d want %b/%0d/%0d",
                     err_flag[0], err_count[0], first_err_addr[0], exp_cnt != 0, exp_cnt, exp_first);
        end
        do_reset();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int a = 0; a < 32; a++) begin
            stuck[a]   = 1'b0;
            ref_mem[a] = 0;
        end
        test_reset();
        test_fill();
        test_fill_check(4'hA, "fill_check");
        stuck[4]  = 1'b1;
        stuck[20] = 1'b1;
        test_fill_check(0, "stuck_bit0");
        stuck[4]  = 1'b0;
        stuck[20] = 1'b0;
        test_all_mismatch();
        test_mode3();
        test_abort();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram32x4_seq_ctrl.md
Name: ram32x4_seq_ctrl

Overview:
Initiator-side controller for a 32-word x 4-bit single-port RAM. It drives the RAM's address, data and write-enable and consumes its read data. On command it fills all 32 words with a seeded pattern, reads them back and checks them, or does both in sequence. It reports a mismatch count and the first failing address, and serves as the built-in memory test and initialiser for the 32x4 RAM blocks.

Parameters:
RD_LAT, 1, RAM read latency in cycles from address presented to ram_q valid. Legal range 0..3.
ADDR_W, 5, RAM address width. Depth is 2**ADDR_W; fixed at 5 for this block.
DATA_W, 4, RAM data width; fixed at 4.

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
start  input  1  command strobe, sampled only in IDLE
mode  input  2  0=fill, 1=check, 2=fill-then-check, 3=reserved no-op
seed  input  4  pattern seed, sampled with start
ram_address  output  5  RAM address
ram_data  output  4  RAM write data
ram_wren  output  1  RAM write enable
ram_q  input  4  RAM read data
busy  output  1  high while a command executes
done  output  1  one-cycle completion pulse
err_flag  output  1  at least one mismatch in last check
err_count  output  6  mismatches in last check (0..32)
first_err_addr  output  5  address of first mismatch, 0 if none

Behaviour:
- Reset: resetn low at a rising edge puts the block in IDLE. All outputs go to 0: ram_address, ram_data, ram_wren, busy, done, err_flag, err_count, first_err_addr. Reset mid-command aborts immediately; ram_wren is 0 from the next cycle. No partial completion or done pulse follows.
- Pattern: expected(a) = (seed + a[3:0]) mod 16. It is computed the same way for fill and check.
- States: IDLE, FILL, CHECK, DRAIN, DONE.
- IDLE
  - busy=0, ram_wren=0.
  - When start=1 at edge N, mode and seed are latched.
  - Next state: FILL for mode 0/2, CHECK for mode 1, DONE for mode 3.
  - busy=1 from cycle N+1.
- FILL
  - Runs 32 cycles. ram_wren=1, ram_address=0..31 incrementing, ram_data=expected(address).
  - After address 31: mode 0 goes to DONE; mode 2 goes to CHECK.
- CHECK
  - Runs 32 cycles. ram_wren=0, ram_address=0..31.
  - On entry, err_count, err_flag and first_err_addr clear to 0.
  - Each issued address and its expected value travel through an RD_LAT-deep valid/address/expected pipeline. With RD_LAT=0 the compare happens in the same cycle.
  - A valid pipeline output with ram_q != expected increments err_count and sets err_flag. If it is the first mismatch, it also loads first_err_addr.
- DRAIN
  - Lasts RD_LAT cycles and is skipped when RD_LAT=0.
  - ram_wren=0. The pipeline empties and compares continue.
  - Then goes to DONE.
- DONE
  - One cycle: done=1, busy=0, then IDLE.
  - Error outputs hold until the next check begins or reset.
  - Fill-only (mode 0) and mode 3 leave the error outputs unchanged.
- Latency, with start at edge N:
  - mode 0: done in cycle N+33.
  - mode 1: done at N+33+RD_LAT.
  - mode 2: done at N+65+RD_LAT.
  - mode 3: done at N+1.
- While busy=1, start is ignored; mode and seed changes have no effect.
- start asserted in the DONE cycle is ignored. It is accepted again from IDLE.
- Address counter wraps 31→0 only at a phase end. ram_address returns to 0 in IDLE and DONE.
- err_count saturates naturally at 32; no overflow is possible in 6 bits.

Test Plan:
- Fill with RAM model, seed=4'h3, mode=0 → ram_wren=1 for exactly 32 cycles at addresses 0..31. ram_data at address 13 = 4'h0. done at N+33. Error outputs remain 0.
- mode=2, seed=4'hA, RD_LAT=1, fault-free RAM → done at N+66, err_flag=0, err_count=0, first_err_addr=0.
- mode=2 with RAM stuck-at bit0=1 at addresses 4 and 20, seed=0 → err_count=2, first_err_addr=4, err_flag=1.
- mode=1 after filling seed=5, checking with seed=6 → all 32 mismatch: err_count=32, first_err_addr=0. Repeat with RD_LAT=0 and RD_LAT=3; done timing follows N+33+RD_LAT.
- resetn low for one cycle at FILL address 10 → next cycle ram_wren=0, busy=0, state IDLE, no done pulse. A new start is then accepted normally.
- start pulsed repeatedly while busy, and start held high through the DONE cycle → no restart mid-command and exactly one done pulse per accepted command. mode=3 → done at N+1 with error outputs unchanged.
